// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port MEM arbiter: FSM encodings, port ids, default widths.
package mem_port_arbiter_pkg;

  localparam int ARB_ADDR_W   = 16;
  localparam int ARB_DATA_W   = 16;
  localparam int ARB_MAX_LOCK = 4;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_LOCK0 = 2'd2,
    ST_LOCK1 = 2'd3
  } arb_state_e;

  function automatic arb_state_e lock_state(input logic port);
    return (port == PORT1) ? ST_LOCK1 : ST_LOCK0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the port that did not win last time is chosen.
module arb_rr_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic sel,
  output logic any
);

  always_comb begin
    any = req0 | req1;
    if (req0 && req1) begin
      sel = (last == PORT0) ? PORT1 : PORT0;
    end else begin
      sel = req1 ? PORT1 : PORT0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port MEM between processor (port 0) and aux master (port 1):
// round-robin grant, bounded lock for bursts, registered read-return path.
//
// state    | meaning
// ST_IDLE  | no grant issued last cycle
// ST_GRANT | a normal round-robin grant was issued last cycle
// ST_LOCK0 | port 0 holds a lock; lock_cnt counts its consecutive grants
// ST_LOCK1 | port 1 holds a lock; lock_cnt counts its consecutive grants
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int MAX_LOCK = ARB_MAX_LOCK
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              wr0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] q0,
  input  logic              req1,
  input  logic              wr1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] q1,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int                CNT_W   = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_LOCK);

  arb_state_e        state, state_nxt;
  logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
  logic              last;
  logic              rd_pend;
  logic              rd_port;
  logic [DATA_W-1:0] q0_hold, q1_hold;

  logic rr_sel, rr_any;
  logic pick_any, pick_sel;
  logic lk_port, lk_req, lk_lock, oth_req, sel_lock;
  logic gnt_v;

  arb_rr_pick u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (last),
    .sel  (rr_sel),
    .any  (rr_any)
  );

  always_ff @(posedge Clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      lock_cnt <= '0;
      last     <= PORT1;
      rd_pend  <= 1'b0;
      rd_port  <= PORT0;
      q0_hold  <= '0;
      q1_hold  <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      if (gnt_v) begin
        last <= pick_sel;
      end
      rd_pend <= gnt_v & ~mem_wr;
      rd_port <= pick_sel;
      if (rvalid0) begin
        q0_hold <= mem_q;
      end
      if (rvalid1) begin
        q1_hold <= mem_q;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = '0;
    pick_any     = 1'b0;
    pick_sel     = PORT0;
    lk_port      = (state == ST_LOCK1) ? PORT1 : PORT0;
    lk_req       = lk_port ? req1 : req0;
    lk_lock      = lk_port ? lock1 : lock0;
    oth_req      = lk_port ? req0 : req1;
    sel_lock     = rr_sel ? lock1 : lock0;

    case (state)
      ST_LOCK0, ST_LOCK1: begin
        if (lk_req && lk_lock && (lock_cnt < MAX_CNT)) begin
          pick_any     = 1'b1;
          pick_sel     = lk_port;
          lock_cnt_nxt = lock_cnt + CNT_W'(1);
        end else if (lk_req && (lock_cnt >= MAX_CNT)) begin
          // Lock expired: hand the slot to the other port if it is waiting.
          pick_any  = 1'b1;
          pick_sel  = oth_req ? ~lk_port : lk_port;
          state_nxt = ST_GRANT;
        end else begin
          pick_any  = rr_any;
          pick_sel  = rr_sel;
          state_nxt = rr_any ? ST_GRANT : ST_IDLE;
        end
      end
      default: begin
        pick_any = rr_any;
        pick_sel = rr_sel;
        if (!rr_any) begin
          state_nxt = ST_IDLE;
        end else if (sel_lock) begin
          state_nxt    = lock_state(rr_sel);
          lock_cnt_nxt = CNT_W'(1);
        end else begin
          state_nxt = ST_GRANT;
        end
      end
    endcase
  end

  // Grants and read returns are masked while reset is asserted so nothing leaks mid-reset.
  assign gnt_v = reset & pick_any;
  assign gnt0  = gnt_v & (pick_sel == PORT0);
  assign gnt1  = gnt_v & (pick_sel == PORT1);

  always_comb begin
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (gnt_v) begin
      mem_wr   = pick_sel ? wr1   : wr0;
      mem_addr = pick_sel ? addr1 : addr0;
      mem_data = pick_sel ? data1 : data0;
    end
  end

  assign rvalid0 = reset & rd_pend & (rd_port == PORT0);
  assign rvalid1 = reset & rd_pend & (rd_port == PORT1);

  always_comb begin
    q0 = '0;
    q1 = '0;
    if (reset) begin
      q0 = rvalid0 ? mem_q : q0_hold;
      q1 = rvalid1 ? mem_q : q1_hold;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural single-port MEM attached.
module tb_mem_port_arbiter;

  logic        Clock;
  logic        reset;
  logic        req0, wr0, lock0, req1, wr1, lock1;
  logic [15:0] addr0, data0, addr1, data1;
  logic        gnt0, rvalid0, gnt1, rvalid1;
  logic [15:0] q0, q1;
  logic        mem_wr;
  logic [15:0] mem_addr, mem_data, mem_q;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    logic        port;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } gnt_t;

  typedef struct {
    int          cyc;
    logic        port;
    logic [15:0] q;
  } rd_t;

  gnt_t gq[$];
  rd_t  rq[$];

  logic [15:0] mem [0:255];

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_LOCK(4)) dut (
    .Clock(Clock), .reset(reset),
    .req0(req0), .wr0(wr0), .lock0(lock0), .addr0(addr0), .data0(data0),
    .gnt0(gnt0), .rvalid0(rvalid0), .q0(q0),
    .req1(req1), .wr1(wr1), .lock1(lock1), .addr1(addr1), .data1(data1),
    .gnt1(gnt1), .rvalid1(rvalid1), .q1(q1),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data), .mem_q(mem_q)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  // MEM model: sync write, registered read; known words are preloaded while reset is low.
  always @(posedge Clock) begin
    if (!reset) begin
      mem[5] <= 16'h00A3;
      mem[7] <= 16'h1234;
    end else if (mem_wr) begin
      mem[mem_addr[7:0]] <= mem_data;
    end
    mem_q <= mem[mem_addr[7:0]];
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge Clock) begin
    if (reset) begin
      chk("one_gnt_only", 32'(gnt0 & gnt1), 32'd0);
      chk("wr_without_gnt", 32'(mem_wr & ~(gnt0 | gnt1)), 32'd0);
      chk("one_rvalid_only", 32'(rvalid0 & rvalid1), 32'd0);
      if (gnt0 || gnt1) begin
        if (gq.size() == 0) begin
          chk("unexpected_gnt", 32'(gnt1), 32'hFFFF_FFFF);
        end else begin
          gnt_t e;
          e = gq.pop_front();
          chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
          chk("gnt_port", 32'(gnt1), 32'(e.port));
          chk("mem_wr", 32'(mem_wr), 32'(e.wr));
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          chk("mem_data", 32'(mem_data), 32'(e.data));
        end
      end
      if (rvalid0 || rvalid1) begin
        if (rq.size() == 0) begin
          chk("unexpected_rvalid", 32'(rvalid1), 32'hFFFF_FFFF);
        end else begin
          rd_t r;
          r = rq.pop_front();
          chk("rvalid_cycle", 32'(cyc), 32'(r.cyc));
          chk("rvalid_port", 32'(rvalid1), 32'(r.port));
          chk("rdata", 32'(rvalid1 ? q1 : q0), 32'(r.q));
        end
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic l0,
                       input logic [15:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [15:0] a1, input logic [15:0] d1);
    req0 = r0; wr0 = w0; lock0 = l0; addr0 = a0; data0 = d0;
    req1 = r1; wr1 = w1; lock1 = l1; addr1 = a1; data1 = d1;
  endtask

  task automatic exp_gnt(input logic p, input logic w, input logic [15:0] a, input logic [15:0] d);
    gnt_t e;
    e.cyc = cyc; e.port = p; e.wr = w; e.addr = a; e.data = d;
    gq.push_back(e);
  endtask

  task automatic exp_rd(input logic p, input logic [15:0] q);
    rd_t r;
    r.cyc = cyc + 1; r.port = p; r.q = q;
    rq.push_back(r);
  endtask

  task automatic chk_all_quiet();
    @(negedge Clock);
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    chk("rst_q0", 32'(q0), 32'd0);
    chk("rst_q1", 32'(q1), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);

    // Reset held two cycles with both ports requesting.
    step();
    drive(1, 0, 0, 16'h0005, 16'h0, 1, 0, 0, 16'h0007, 16'h0);
    chk_all_quiet();
    step();
    chk_all_quiet();

    // Release: port 0 wins the first tie, then strict alternation.
    step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic p;
      p = (i % 2 == 1);
      exp_gnt(p, 1'b0, p ? 16'h0007 : 16'h0005, 16'h0);
      exp_rd(p, p ? 16'h1234 : 16'h00A3);
      step();
    end
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    step();

    // Single read by port 0.
    drive(1, 0, 0, 16'h0005, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    exp_gnt(1'b0, 1'b0, 16'h0005, 16'h0);
    exp_rd(1'b0, 16'h00A3);
    step();

    // Port 1 locked against a waiting port 0: four grants, then port 0.
    drive(1, 0, 0, 16'h0005, 16'h0, 1, 0, 1, 16'h0007, 16'h0);
    for (int k = 0; k < 4; k++) begin
      exp_gnt(1'b1, 1'b0, 16'h0007, 16'h0);
      exp_rd(1'b1, 16'h1234);
      step();
    end
    exp_gnt(1'b0, 1'b0, 16'h0005, 16'h0);
    exp_rd(1'b0, 16'h00A3);
    step();
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    step();

    // Port 1 writes, port 0 reads the same word back.
    drive(0, 0, 0, 16'h0, 16'h0, 1, 1, 0, 16'h0010, 16'hBEEF);
    exp_gnt(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    step();
    drive(1, 0, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    exp_gnt(1'b0, 1'b0, 16'h0010, 16'h0);
    exp_rd(1'b0, 16'hBEEF);
    step();
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    step();
    step();
    @(negedge Clock);
    chk("q0_held", 32'(q0), 32'h0000_BEEF);
    chk("q1_held", 32'(q1), 32'h0000_1234);

    // Reset right after a read grant: the return is dropped and q cleared.
    step();
    drive(1, 0, 0, 16'h0005, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    exp_gnt(1'b0, 1'b0, 16'h0005, 16'h0);
    step();
    reset = 1'b0;
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    chk_all_quiet();
    step();
    reset = 1'b1;
    drive(1, 0, 0, 16'h0005, 16'h0, 1, 0, 0, 16'h0007, 16'h0);
    exp_gnt(1'b0, 1'b0, 16'h0005, 16'h0);
    exp_rd(1'b0, 16'h00A3);
    @(negedge Clock);
    chk("q0_after_reset", 32'(q0), 32'd0);
    chk("rvalid0_after_reset", 32'(rvalid0), 32'd0);
    step();
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    step();
    step();

    chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
    chk("rd_queue_drained", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
